// File: rtl/fft32_mem_ctrl.sv
// Sequencing controller for a 32-point radix-2 in-place FFT on a dual-port
// 32x16 RAM. It loads samples in bit-reversed order, then runs 5 stages of
// 16 butterflies (read pair, wait for the datapath, write pair back), and
// finally streams the results out in natural order.
module fft32_mem_ctrl #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] addra,
  output logic [4:0] addrb,
  output logic       ena,
  output logic       enb,
  output logic       dsel,
  output logic       bf_go,
  output logic [3:0] tw_idx,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RD     = 3'd2,
    WT     = 3'd3,
    WR     = 3'd4,
    UNLOAD = 3'd5
  } state_t;

  state_t        state;
  // cnt: sample index in LOAD; in UNLOAD 0..31 are address beats, 32 is the
  // last data beat and 33 is the done cycle, so busy spans through done.
  logic [5:0]    cnt;
  logic [2:0]    stg;
  logic [3:0]    bfly;
  logic [WW-1:0] wcnt;

  logic [4:0]    base;
  logic [4:0]    span;
  logic [3:0]    tw;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // Lower index of butterfly b in stage s: insert a zero at bit position s.
  function automatic logic [4:0] bf_base(input logic [2:0] s, input logic [3:0] b);
    logic [4:0] bb;
    logic [4:0] msk;
    bb  = {1'b0, b};
    msk = (5'd1 << s) - 5'd1;
    return ((bb >> s) << (s + 3'd1)) | (bb & msk);
  endfunction

  function automatic logic [3:0] bf_tw(input logic [2:0] s, input logic [3:0] b);
    logic [4:0] msk;
    msk = (5'd1 << s) - 5'd1;
    return (b & msk[3:0]) << (3'd4 - s);
  endfunction

  assign base = bf_base(stg, bfly);
  assign span = 5'd1 << stg;
  assign tw   = bf_tw(stg, bfly);

  // Phase sequencing: load count, stage/butterfly indices and datapath wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      stg   <= '0;
      bfly  <= '0;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt == 6'd31) begin
              state <= RD;
              cnt   <= '0;
              stg   <= '0;
              bfly  <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        RD: begin
          state <= WT;
          wcnt  <= '0;
        end
        WT: begin
          if (wcnt == WW'(LAT - 1)) begin
            state <= WR;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        WR: begin
          if (bfly != 4'd15) begin
            bfly  <= bfly + 4'd1;
            state <= RD;
          end else if (stg != 3'd4) begin
            stg   <= stg + 3'd1;
            bfly  <= '0;
            state <= RD;
          end else begin
            cnt   <= '0;
            state <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (cnt == 6'd33) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state; write enables are dropped while
  // rst is high so a write in flight at reset never reaches the RAM.
  always_comb begin
    in_ready  = 1'b0;
    addra     = '0;
    addrb     = '0;
    ena       = 1'b0;
    enb       = 1'b0;
    dsel      = 1'b0;
    bf_go     = 1'b0;
    tw_idx    = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        addra    = bitrev5(cnt[4:0]);
        ena      = in_valid & ~rst;
      end
      RD: begin
        addra  = base;
        addrb  = base + span;
        tw_idx = tw;
      end
      WT: begin
        addra  = base;
        addrb  = base + span;
        tw_idx = tw;
        bf_go  = (wcnt == '0);
      end
      WR: begin
        addra  = base;
        addrb  = base + span;
        tw_idx = tw;
        ena    = ~rst;
        enb    = ~rst;
        dsel   = 1'b1;
      end
      UNLOAD: begin
        addra     = (cnt < 6'd32) ? cnt[4:0] : 5'd0;
        out_valid = (cnt != 6'd0) && (cnt <= 6'd32);
        out_last  = (cnt == 6'd32);
        done      = (cnt == 6'd33);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft32_mem_ctrl.sv
// Bench for fft32_mem_ctrl: two controllers (LAT=1 and LAT=3), each with a
// RAM model and a butterfly datapath over GF(97), so a 32-point number
// theoretic transform is exact and can be compared against a direct DFT.
module tb_fft32_mem_ctrl;

  localparam int P = 97;

  logic       clk;
  logic       rst;
  logic [1:0] start, in_valid, in_ready, ena, enb, dsel, bf_go;
  logic [1:0] out_valid, out_last, busy, done;
  logic [4:0] addra [2];
  logic [4:0] addrb [2];
  logic [3:0] tw_idx [2];

  logic [15:0] sample [2];
  logic [15:0] mem [2][32];
  logic [15:0] doa_m [2];
  logic [15:0] dob_m [2];
  logic [15:0] pa [2][3];
  logic [15:0] pb [2][3];

  logic [16:0] q0 [$];
  logic [16:0] q1 [$];

  int w32;
  int total = 0;
  int bad = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  int cyc = 0;

  int ldcnt [2], bfn [2], last_bf [2], calc_start [2], beats [2], start_cyc [2], stalls [2];
  logic prev_inr [2], prev_last [2], prev_done [2], prev_ov [2];
  logic [4:0] prev_addra [2], bf_a [2], bf_b [2];
  logic rst_seen = 1'b0;

  logic [4:0]  m_ea, m_eb;
  logic [3:0]  m_et;
  logic [16:0] m_e;
  logic [22:0] m_outs;

  for (genvar g = 0; g < 2; g++) begin : gd
    fft32_mem_ctrl #(.LAT(g == 0 ? 1 : 3)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .addra    (addra[g]),
      .addrb    (addrb[g]),
      .ena      (ena[g]),
      .enb      (enb[g]),
      .dsel     (dsel[g]),
      .bf_go    (bf_go[g]),
      .tw_idx   (tw_idx[g]),
      .out_valid(out_valid[g]),
      .out_last (out_last[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int mpow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % P;
    return r;
  endfunction

  function automatic logic [4:0] brev(input int v);
    logic [4:0] t;
    t = 5'(v);
    return {t[0], t[1], t[2], t[3], t[4]};
  endfunction

  // Butterfly n (stage n/16): the (n%16)-th index with bit s clear, its
  // partner one span above, and twiddle exponent (i mod span) * 16/span.
  function automatic void bf_pair(input int n, output logic [4:0] a,
                                  output logic [4:0] b, output logic [3:0] t);
    int s, k, span, seen;
    s = n / 16;
    k = n % 16;
    span = 1 << s;
    seen = 0;
    a = '0;
    for (int i = 0; i < 32; i++) begin
      if ((i & span) == 0) begin
        if (seen == k) a = 5'(i);
        seen++;
      end
    end
    b = a + 5'(span);
    t = 4'((int'(a) % span) * (16 >> s));
  endfunction

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // RAM (synchronous read, write on enable) and butterfly datapath models.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int t;
      doa_m[g] <= mem[g][addra[g]];
      dob_m[g] <= mem[g][addrb[g]];
      if (ena[g]) mem[g][addra[g]] <= dsel[g] ? pa[g][lat_of(g) - 1] : sample[g];
      if (enb[g]) mem[g][addrb[g]] <= pb[g][lat_of(g) - 1];
      if (bf_go[g]) begin
        t = (int'(dob_m[g]) * mpow(w32, int'(tw_idx[g]))) % P;
        pa[g][0] <= 16'((int'(doa_m[g]) + t) % P);
        pb[g][0] <= 16'((int'(doa_m[g]) + P - t) % P);
      end
      pa[g][1] <= pa[g][0];
      pa[g][2] <= pa[g][1];
      pb[g][1] <= pb[g][0];
      pb[g][2] <= pb[g][1];
    end
  end

  // Monitor: protocol checks and scoreboard pops, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (tmo_cnt != tmo_seen) begin
      chk(1'b0, "wait_bound", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
    for (int g = 0; g < 2; g++) begin
      if (rst_seen && !rst) begin
        m_outs = {addra[g], addrb[g], tw_idx[g], ena[g], enb[g], dsel[g], bf_go[g],
                  in_ready[g], out_valid[g], out_last[g], busy[g], done[g]};
        chk(m_outs == '0, "reset_outs", int'(m_outs), 0);
      end
      if (rst) begin
        ldcnt[g] = 0; bfn[g] = 0; beats[g] = 0; stalls[g] = 0;
        prev_inr[g] = 0; prev_last[g] = 0; prev_done[g] = 0; prev_ov[g] = 0;
        if (g == 0) q0.delete(); else q1.delete();
      end else begin
        if (start[g] && !busy[g]) begin
          start_cyc[g] = cyc; ldcnt[g] = 0; bfn[g] = 0; beats[g] = 0; stalls[g] = 0;
        end
        if (in_ready[g]) begin
          if (!in_valid[g]) begin
            stalls[g]++;
            chk(!ena[g], "ena_gap", int'(ena[g]), 0);
          end else begin
            chk(ena[g] && !enb[g] && !dsel[g] && addra[g] == brev(ldcnt[g]),
                "load_wr", int'(addra[g]), int'(brev(ldcnt[g])));
            ldcnt[g]++;
          end
        end
        if (prev_inr[g] && !in_ready[g] && busy[g]) begin
          chk(ldcnt[g] == 32, "load_cnt", ldcnt[g], 32);
          calc_start[g] = cyc;
        end
        if (bf_go[g]) begin
          bf_pair(bfn[g], m_ea, m_eb, m_et);
          chk(addra[g] == m_ea && addrb[g] == m_eb && tw_idx[g] == m_et, "bf_addr",
              int'({addra[g], addrb[g], tw_idx[g]}), int'({m_ea, m_eb, m_et}));
          bf_a[g] = addra[g];
          bf_b[g] = addrb[g];
          last_bf[g] = cyc;
          bfn[g]++;
        end
        if (ena[g] && enb[g]) begin
          chk(cyc - last_bf[g] == lat_of(g) && dsel[g] && addra[g] == bf_a[g] &&
              addrb[g] == bf_b[g], "bf_wr", cyc - last_bf[g], lat_of(g));
        end
        if (out_valid[g]) begin
          if (beats[g] == 0) begin
            chk(cyc - calc_start[g] == 80 * (2 + lat_of(g)) + 1, "calc_len",
                cyc - calc_start[g], 80 * (2 + lat_of(g)) + 1);
            chk(bfn[g] == 80, "bf_count", bfn[g], 80);
          end
          chk(prev_addra[g] == 5'(beats[g]), "unl_addr", int'(prev_addra[g]), beats[g]);
          if ((g == 0 ? q0.size() : q1.size()) == 0) begin
            chk(1'b0, "sb_empty", int'(doa_m[g]), -1);
          end else begin
            m_e = (g == 0) ? q0.pop_front() : q1.pop_front();
            chk({out_last[g], doa_m[g]} == m_e, "out_data",
                int'({out_last[g], doa_m[g]}), int'(m_e));
          end
          beats[g]++;
        end else if (prev_ov[g]) begin
          chk(beats[g] == 32, "ov_burst", beats[g], 32);
        end
        if (done[g]) begin
          chk(prev_last[g] && beats[g] == 32, "done_pos", beats[g], 32);
          chk(cyc - start_cyc[g] == 32 + stalls[g] + 80 * (2 + lat_of(g)) + 34,
              "start_to_done", cyc - start_cyc[g],
              32 + stalls[g] + 80 * (2 + lat_of(g)) + 34);
        end
        if (prev_done[g]) chk(!busy[g], "busy_low", int'(busy[g]), 0);
        prev_inr[g]  = in_ready[g];
        prev_last[g] = out_last[g];
        prev_done[g] = done[g];
        prev_ov[g]   = out_valid[g];
      end
      prev_addra[g] = addra[g];
    end
    rst_seen = rst;
  end

  // One transform on controller g. gap_mode: 0 none, 1 every 3rd cycle, 2 random.
  // abort_bf >= 0 resets the controllers once that many butterflies have fired.
  task automatic run(input int g, input int gap_mode, input bit poke, input int abort_bf);
    logic [15:0] x [32];
    int acc, n, c, guard;
    logic v;
    for (int i = 0; i < 32; i++) x[i] = 16'($urandom_range(0, P - 1));
    if (abort_bf < 0) begin
      for (int k = 0; k < 32; k++) begin
        acc = 0;
        for (int i = 0; i < 32; i++) acc = (acc + int'(x[i]) * mpow(w32, (i * k) % 32)) % P;
        if (g == 0) q0.push_back({k == 31, 16'(acc)});
        else        q1.push_back({k == 31, 16'(acc)});
      end
    end
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    n = 0;
    c = 0;
    while (n < 32 && c < 300) begin
      case (gap_mode)
        1:       v = (c % 3 != 2);
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      in_valid[g] = v;
      sample[g] = x[n];
      if (poke && c == 4) start[g] = 1'b1;
      @(posedge clk); #1;
      start[g] = 1'b0;
      if (v) n++;
      c++;
    end
    in_valid[g] = 1'b0;
    if (n < 32) tmo_cnt++;
    if (abort_bf >= 0) begin
      guard = 0;
      while (bfn[g] < abort_bf && guard < 1000) begin @(posedge clk); #1; guard++; end
      if (bfn[g] < abort_bf) tmo_cnt++;
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
    end else begin
      if (poke) begin
        repeat (100) @(posedge clk);
        #1;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        guard = 0;
        while (!out_valid[g] && guard < 1000) begin @(posedge clk); #1; guard++; end
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
      end
      guard = 0;
      while (!done[g] && guard < 2000) begin @(posedge clk); #1; guard++; end
      if (!done[g]) tmo_cnt++;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    in_valid = '0;
    sample[0] = '0;
    sample[1] = '0;
    w32 = 2;
    while (mpow(w32, 16) != P - 1) w32++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    run(0, 0, 1'b0, -1);
    run(0, 1, 1'b1, -1);
    run(1, 0, 1'b0, -1);
    run(1, 1, 1'b1, -1);
    run(0, 0, 1'b0, 40);
    run(0, 1, 1'b0, -1);
    for (int r = 0; r < 3; r++) run(int'($urandom_range(0, 1)), 2, 1'(r & 1), -1);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft32_mem_ctrl.md
# fft32_mem_ctrl

Sequencing controller for the 32-point radix-2 in-place FFT built around the `RAM_32x16` dual-port memory. It runs three phases on the RAM:
- loads 32 samples in bit-reversed order;
- runs 5 stages × 16 butterflies (read pair, wait for the butterfly, write pair back);
- streams the 32 results out in natural order.

It owns both RAM ports' addresses and write enables, the butterfly trigger, the twiddle index and the RAM write-data source select.

## Interface
Parameters:
- `LAT`, default 1: butterfly datapath latency, in cycles, from `bf_go` to results valid. Must be ≥ 1.

Ports:
- `clk`  in  1  — the single clock; all state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — begins a transform; sampled only in IDLE.
- `in_valid`  in  1  — input sample present (external data on RAM `dia` via `dsel`=0).
- `in_ready`  out  1  — high throughout LOAD.
- `addra`, `addrb`  out  5  — RAM port A/B addresses.
- `ena`, `enb`  out  1  — RAM port A/B write enables.
- `dsel`  out  1  — RAM write-data source: 0 = input sample, 1 = butterfly result.
- `bf_go`  out  1  — one-cycle pulse: RAM `doa`/`dob` hold a valid operand pair.
- `tw_idx`  out  4  — twiddle index k of W32^k, valid while `bf_go` is high.
- `out_valid`  out  1  — RAM `doa` carries an output sample this cycle.
- `out_last`  out  1  — with `out_valid`, marks sample index 31.
- `busy`  out  1  — state ≠ IDLE.
- `done`  out  1  — one-cycle pulse after the last output.

## Operation
- RAM model: synchronous read on each port every cycle (data appears one cycle after the address); a port writes when its enable is high.
- States: IDLE → LOAD → RD → WT → WR → (RD | UNLOAD) → IDLE.
- **IDLE**
  - `start`=1 → LOAD; count clears to 0.
  - `start` is ignored in every other state.
- **LOAD**
  - `in_ready`=1, `dsel`=0, `addra`=bitrev5(cnt), `ena`=`in_valid` (combinational), `enb`=0.
  - Each accepted sample increments cnt.
  - Accepting with cnt=31 → RD with stage s=0, butterfly b=0.
  - Gaps in `in_valid` stall the phase with no write.
- **Butterfly addressing**
  - span = 1<<s.
  - i = ((b>>s)<<(s+1)) | (b & (span−1)).
  - `addra`=i, `addrb`=i+span.
  - `tw_idx` = (b & (span−1)) << (4−s).
- **RD** (1 cycle): addresses driven, `ena`=`enb`=0 → WT.
- **WT** (`LAT` cycles)
  - `bf_go`=1 in the first WT cycle only; addresses held.
  - After `LAT` cycles → WR.
- **WR** (1 cycle)
  - `ena`=`enb`=1, `dsel`=1, addresses still i / i+span.
  - Then:
    - b<15: b+1 → RD.
    - b=15 and s<4: s+1, b=0 → RD.
    - b=15 and s=4: cnt=0 → UNLOAD.
- **UNLOAD**
  - `addra`=cnt for 32 consecutive cycles, with no backpressure.
  - `out_valid` is high in the cycle after each address; `out_last` accompanies the address-31 data.
  - After the final beat, `done` pulses for 1 cycle and the state returns to IDLE.
- RAM contents are never cleared by the controller.

## Timing
- Reset: state IDLE; all outputs 0 (`addra`, `addrb`, `tw_idx`, `ena`, `enb`, `dsel`, `bf_go`, `in_ready`, `out_valid`, `out_last`, `busy`, `done`).
- `rst` wins over every other input. Reset in any state → IDLE on that edge; any in-flight write is abandoned.
- Per butterfly: 2+`LAT` cycles. CALC phase total: 80·(2+`LAT`) cycles (240 at `LAT`=1).
- No read/write overlap between butterflies, so there is no RAW hazard across stages.
- UNLOAD: 32 address cycles. The first `out_valid` comes 1 cycle after UNLOAD entry; `done` comes 1 cycle after `out_last`.
- Minimum start-to-done at `LAT`=1 with `in_valid` continuously high: 32 + 240 + 33 cycles, plus 1 IDLE→LOAD cycle.
- `busy` is registered: high from the cycle after `start` is accepted until the cycle after `done`.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-CALC (s=2) → next cycle all outputs 0, `busy`=0; a subsequent `start` restarts cleanly at LOAD cnt=0.
- **Load order:** `start`, then 32 samples with `in_valid` low every 3rd cycle.
  - Sample 1 writes `addra`=16, sample 3 writes `addra`=24.
  - `ena` is never high while `in_valid`=0.
  - Exactly 32 writes occur.
- **Butterfly addressing**, `LAT`=1:
  - s=0, b=0 → (0,1), `tw_idx`=0.
  - s=2, b=5 → (9,13), `tw_idx`=4.
  - s=4, b=15 → (15,31), `tw_idx`=15.
  - `bf_go` occurs 1 cycle after RD.
  - `ena`/`enb` assert exactly 2 cycles after RD.
- **Cycle count:** `LAT`=3 → CALC phase is 400 cycles and exactly 80 `bf_go` pulses. The bench checks the RAM contents against a golden FFT model through the unload.
- **Unload:** 32 consecutive `out_valid` beats reading addresses 0..31; `out_last` on beat 32 only; `done` 1 cycle later; `busy` low the next cycle.
- **Ignored start:** `start` pulsed during LOAD, CALC and UNLOAD → no state or count change; the final output sequence is identical to an undisturbed run.
